gray_counter_ud: RTL and testbench

- Parametrised up/down Gray-code counter with synchronous load, enable, registered binary and Gray outputs, and a one-cycle wrap pulse.
- Successor to the fixed-width up-only Gray counter used in the liveness benchmarks.
- Serves as the design under test for property suites: response/recurrence of `wrap`, and adjacency of Gray codes.
- Also usable as a pointer generator for clock-domain-crossing FIFOs.

---
 rtl/gray_pkg.sv | 25 ++
 rtl/gray_adj_check.sv | 40 ++++
 rtl/gray_counter_ud.sv | 80 ++++++++
 tb/tb_gray_counter_ud.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and direction type for the up/down Gray counter.
package gray_pkg;

   localparam int unsigned GrayMaxWidth = 32;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } gray_dir_e;

   // Callers zero-extend to GrayMaxWidth and truncate the result back to their width.
   function automatic logic [GrayMaxWidth-1:0] bin2gray(input logic [GrayMaxWidth-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [GrayMaxWidth-1:0] gray2bin(input logic [GrayMaxWidth-1:0] gray);
      logic [GrayMaxWidth-1:0] bin;
      bin[GrayMaxWidth-1] = gray[GrayMaxWidth-1];
      for (int i = GrayMaxWidth - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_adj_check.sv
// Sticky checker: flags any counting step whose Gray codes differ in other than one bit.
module gray_adj_check #(
   parameter int unsigned WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chk_en,
   input  logic [WIDTH-1:0] gray,
   output logic             adj_err
);

   logic [WIDTH-1:0] prev_q;
   logic             chk_q;
   logic             err_q;
   logic             err_now;

   // chk_q marks that the edge which produced the current gray was a counting edge.
   assign err_now = chk_q && ($countones(prev_q ^ gray) != 1);
   assign adj_err = err_q | err_now;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q <= '0;
         chk_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         prev_q <= gray;
         chk_q  <= chk_en;
         err_q  <= err_q | err_now;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && chk_q) begin
         assert ($countones(prev_q ^ gray) == 1)
         else $warning("gray_adj_check: non-adjacent Gray step %h -> %h", prev_q, gray);
      end
   end

endmodule

// File: rtl/gray_counter_ud.sv
// Up/down Gray counter with load, enable and one-cycle wrap pulse.
// Define GRAY_ADJ_CHECK_EN to add the sticky adj_err adjacency checker output.
module gray_counter_ud
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH   = 11,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin_cnt,
   output logic [WIDTH-1:0] gray_cnt,
   output logic             wrap
`ifdef GRAY_ADJ_CHECK_EN
   ,
   output logic             adj_err
`endif
);

   localparam logic [WIDTH-1:0] RstBin  = RST_VAL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] RstGray = RstBin ^ (RstBin >> 1);

   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;
   gray_dir_e        dir;

   assign dir = gray_dir_e'(up);

   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      if (load) begin
         bin_d = load_val;
      end else if (en) begin
         if (dir == DIR_UP) begin
            bin_d  = bin_q + 1'b1;
            wrap_d = (bin_q == {WIDTH{1'b1}});
         end else begin
            bin_d  = bin_q - 1'b1;
            wrap_d = (bin_q == '0);
         end
      end
      // Gray derives from the next binary value so both registers update in lockstep.
      gray_d = WIDTH'(bin2gray(GrayMaxWidth'(bin_d)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q  <= RstBin;
         gray_q <= RstGray;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign bin_cnt  = bin_q;
   assign gray_cnt = gray_q;
   assign wrap     = wrap_q;

`ifdef GRAY_ADJ_CHECK_EN
   gray_adj_check #(
      .WIDTH (WIDTH)
   ) u_adj_check (
      .clk     (clk),
      .rst     (rst),
      .chk_en  (en & ~load),
      .gray    (gray_cnt),
      .adj_err (adj_err)
   );
`endif

endmodule

// File: tb/tb_gray_counter_ud.sv
// Directed bench for gray_counter_ud at WIDTH=4 (RST_VAL 0 and 3 instances).
module tb_gray_counter_ud;

   logic       clk;
   logic       rst;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] bin_cnt, gray_cnt, bin3, gray3;
   logic       wrap, wrap3;
`ifdef GRAY_ADJ_CHECK_EN
   logic       adj_err, adj_err3;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       load;
      logic       en;
      logic       up;
      logic [3:0] lv;
      logic [3:0] eb;
      logic [3:0] eg;
      logic       ew;
   } vec_t;

   vec_t       vecs[$];
   logic [3:0] gseq[16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                            4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

   gray_counter_ud #(
      .WIDTH   (4),
      .RST_VAL (0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .bin_cnt  (bin_cnt),
      .gray_cnt (gray_cnt),
      .wrap     (wrap)
`ifdef GRAY_ADJ_CHECK_EN
      ,
      .adj_err  (adj_err)
`endif
   );

   gray_counter_ud #(
      .WIDTH   (4),
      .RST_VAL (3)
   ) dut3 (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .bin_cnt  (bin3),
      .gray_cnt (gray3),
      .wrap     (wrap3)
`ifdef GRAY_ADJ_CHECK_EN
      ,
      .adj_err  (adj_err3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic l, input logic e, input logic u, input logic [3:0] v);
      load     = l;
      en       = e;
      up       = u;
      load_val = v;
   endtask

   function automatic void add(input logic l, input logic e, input logic u, input logic [3:0] v,
                               input logic [3:0] eb, input logic [3:0] eg, input logic ew);
      vecs.push_back('{load: l, en: e, up: u, lv: v, eb: eb, eg: eg, ew: ew});
   endfunction

   initial begin
      for (int i = 0; i < 16; i++) add(0, 1, 1, 4'h0, 4'(i + 1), gseq[i], i == 15);
      add(0, 1, 0, 4'h0, 4'hF, 4'h8, 1);
      add(0, 1, 0, 4'h0, 4'hE, 4'h9, 0);
      add(1, 1, 1, 4'h5, 4'h5, 4'h7, 0);
      add(0, 1, 1, 4'h0, 4'h6, 4'h5, 0);
      add(0, 1, 1, 4'h0, 4'h7, 4'h4, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 1, 4'h0, 4'h7, 4'h4, 0);
      add(0, 1, 0, 4'h0, 4'h6, 4'h5, 0);
      add(1, 0, 0, 4'hF, 4'hF, 4'h8, 0);
      add(0, 1, 1, 4'h0, 4'h0, 4'h0, 1);
      add(0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
      add(0, 1, 0, 4'h0, 4'hF, 4'h8, 1);
      add(0, 1, 0, 4'h0, 4'hE, 4'h9, 0);
      add(1, 1, 0, 4'h0, 4'h0, 4'h0, 0);

      rst = 1'b1;
      drive(0, 0, 0, 4'h0);
      #1;
      chk("reset_bin", bin_cnt, 4'h0);
      chk("reset_gray", gray_cnt, 4'h0);
      chk("reset_wrap", {3'b0, wrap}, 4'h0);
      chk("reset3_bin", bin3, 4'h3);
      chk("reset3_gray", gray3, 4'h2);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].lv);
         step();
         chk($sformatf("vec%0d_bin", i), bin_cnt, vecs[i].eb);
         chk($sformatf("vec%0d_gray", i), gray_cnt, vecs[i].eg);
         chk($sformatf("vec%0d_wrap", i), {3'b0, wrap}, {3'b0, vecs[i].ew});
      end

      // Asynchronous reset at bin=F while counting up: no wait for clk, no wrap.
      drive(1, 0, 0, 4'hF);
      step();
      chk("pre_rst_bin", bin_cnt, 4'hF);
      chk("pre_rst3_bin", bin3, 4'hF);
      drive(0, 1, 1, 4'h0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_bin", bin_cnt, 4'h0);
      chk("async_rst_gray", gray_cnt, 4'h0);
      chk("async_rst_wrap", {3'b0, wrap}, 4'h0);
      chk("async_rst3_bin", bin3, 4'h3);
      chk("async_rst3_gray", gray3, 4'h2);
      step();
      chk("held_rst_bin", bin_cnt, 4'h0);
      chk("held_rst_wrap", {3'b0, wrap}, 4'h0);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("post_rst_bin", bin_cnt, 4'h1);
      chk("post_rst_gray", gray_cnt, 4'h1);
      chk("post_rst3_bin", bin3, 4'h4);
      chk("post_rst3_gray", gray3, 4'h6);

      // Reset clears a pending wrap pulse immediately.
      drive(1, 0, 0, 4'hF);
      step();
      drive(0, 1, 1, 4'h0);
      step();
      chk("wrap_before_rst", {3'b0, wrap}, 4'h1);
      chk("wrap3_before_rst", {3'b0, wrap3}, 4'h1);
      #2 rst = 1'b1;
      #1;
      chk("wrap_cleared", {3'b0, wrap}, 4'h0);
      chk("wrap3_cleared", {3'b0, wrap3}, 4'h0);
      @(negedge clk);
      rst = 1'b0;

      // Count down straight out of reset.
      drive(0, 1, 0, 4'h0);
      step();
      chk("down_bin", bin_cnt, 4'hF);
      chk("down_gray", gray_cnt, 4'h8);
      chk("down_wrap", {3'b0, wrap}, 4'h1);
      chk("down3_bin", bin3, 4'h2);
      chk("down3_wrap", {3'b0, wrap3}, 4'h0);
      step();
      chk("down2_bin", bin_cnt, 4'hE);
      chk("down2_gray", gray_cnt, 4'h9);
      chk("down2_wrap", {3'b0, wrap}, 4'h0);
      chk("down23_gray", gray3, 4'h1);

`ifdef GRAY_ADJ_CHECK_EN
      begin
         logic [3:0] fval;
         for (int i = 0; i < 1000; i++) begin
            drive($urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), 4'($urandom));
            step();
         end
         chk("adj_clean", {3'b0, adj_err}, 4'h0);
         chk("adj3_clean", {3'b0, adj_err3}, 4'h0);
         drive(0, 1, 1, 4'h0);
         step();
         fval = gray_cnt ^ 4'b0101;
         force dut.gray_q = fval;
         drive(0, 0, 0, 4'h0);
         step();
         release dut.gray_q;
         chk("adj_set", {3'b0, adj_err}, 4'h1);
         step();
         step();
         chk("adj_sticky", {3'b0, adj_err}, 4'h1);
         chk("adj3_untouched", {3'b0, adj_err3}, 4'h0);
         rst = 1'b1;
         #1;
         chk("adj_rst", {3'b0, adj_err}, 4'h0);
         @(negedge clk);
         rst = 1'b0;
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
